// File: rtl/sll_pkg.sv
// Shared types and defaults for the iterative logical left shifter.
package sll_pkg;

  localparam int unsigned SLL_WIDTH   = 32;
  localparam int unsigned SLL_SHAMT_W = 5;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } sll_state_e;

  // Stage k applies the binary distance 2^(shamt_w-1-k), MSB stage first.
  function automatic int unsigned stage_dist(input int unsigned shamt_w, input int unsigned k);
    return 32'd1 << (shamt_w - 1 - k);
  endfunction

endpackage

// File: rtl/sll_stage.sv
// One binary shift stage: shifts the working word by the stage distance when enabled and
// flags any 1 bit pushed out of the top.
module sll_stage
  import sll_pkg::*;
#(
  parameter int unsigned WIDTH   = SLL_WIDTH,
  parameter int unsigned SHAMT_W = SLL_SHAMT_W
) (
  input  logic [WIDTH-1:0]   work_i,
  input  logic [SHAMT_W-1:0] stage_i,
  input  logic               enable_i,
  output logic [WIDTH-1:0]   shifted_o,
  output logic               spill_o
);

  always_comb begin
    shifted_o = work_i;
    spill_o   = 1'b0;
    if (enable_i) begin
      for (int k = 0; k < SHAMT_W; k++) begin
        if (stage_i == SHAMT_W'(k)) begin
          shifted_o = work_i << stage_dist(SHAMT_W, k);
          // Top s bits of the word are the ones that fall off
          spill_o   = |(work_i >> (WIDTH - stage_dist(SHAMT_W, k)));
        end
      end
    end
  end

endmodule

// File: rtl/sll_seq.sv
// Iterative logical left shifter, one binary stage per clock, start/ready handshake.
// Define SLL_EARLY_DONE_EN to complete as soon as the remaining shift-amount bits are zero.
module sll_seq
  import sll_pkg::*;
#(
  parameter int unsigned WIDTH   = SLL_WIDTH,
  parameter int unsigned SHAMT_W = SLL_SHAMT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_shift,
  input  logic [WIDTH-1:0]   operand,
  input  logic [SHAMT_W-1:0] shift_amt,
  output logic [WIDTH-1:0]   result,
  output logic               result_rdy,
  output logic               lost,
  output logic               busy
);

  sll_state_e         state_q;
  logic [WIDTH-1:0]   work_q;
  logic [SHAMT_W-1:0] amt_q;
  logic [SHAMT_W-1:0] stage_q;
  logic               lost_acc_q;
  logic [WIDTH-1:0]   result_q;
  logic               lost_q;
  logic               result_rdy_q;
  logic               busy_q;

  logic [WIDTH-1:0]   stage_out;
  logic               stage_spill;
  logic               stage_en;
  logic               finish;

  // Select this stage's amount bit and decide whether this edge completes the operation
  always_comb begin
    stage_en = 1'b0;
    finish   = 1'b0;
    for (int k = 0; k < SHAMT_W; k++) begin
      if (stage_q == SHAMT_W'(k)) begin
        stage_en = amt_q[SHAMT_W-1-k];
`ifdef SLL_EARLY_DONE_EN
        finish   = (k == SHAMT_W - 1) ||
                   ((amt_q & SHAMT_W'(stage_dist(SHAMT_W, k) - 1)) == '0);
`else
        finish   = (k == SHAMT_W - 1);
`endif
      end
    end
  end

  sll_stage #(
    .WIDTH  (WIDTH),
    .SHAMT_W(SHAMT_W)
  ) u_stage (
    .work_i   (work_q),
    .stage_i  (stage_q),
    .enable_i (stage_en),
    .shifted_o(stage_out),
    .spill_o  (stage_spill)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      work_q       <= '0;
      amt_q        <= '0;
      stage_q      <= '0;
      lost_acc_q   <= 1'b0;
      result_q     <= '0;
      lost_q       <= 1'b0;
      result_rdy_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          result_rdy_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= StIdle;
          if (ctrl_shift) begin
            work_q     <= operand;
            amt_q      <= shift_amt;
            lost_acc_q <= 1'b0;
            stage_q    <= '0;
            state_q    <= StShift;
            busy_q     <= 1'b1;
`ifdef SLL_EARLY_DONE_EN
            if (shift_amt == '0) begin
              result_q     <= operand;
              lost_q       <= 1'b0;
              state_q      <= StDone;
              result_rdy_q <= 1'b1;
              busy_q       <= 1'b0;
            end
`endif
          end
        end
        StShift: begin
          work_q     <= stage_out;
          lost_acc_q <= lost_acc_q | stage_spill;
          stage_q    <= stage_q + 1'b1;
          if (finish) begin
            result_q     <= stage_out;
            lost_q       <= lost_acc_q | stage_spill;
            state_q      <= StDone;
            result_rdy_q <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign result     = result_q;
  assign lost       = lost_q;
  assign result_rdy = result_rdy_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sll_seq.sv
// Scoreboard bench for sll_seq: directed starts push expected results, a monitor checks each
// result_rdy pulse for value, lost flag and arrival cycle.
module tb_sll_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_shift;
  logic [31:0] operand;
  logic [4:0]  shift_amt;
  logic [31:0] result;
  logic        result_rdy;
  logic        lost;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    logic        lst;
    int          at_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  sll_seq dut (
    .clock     (clock),
    .reset     (reset),
    .ctrl_shift(ctrl_shift),
    .operand   (operand),
    .shift_amt (shift_amt),
    .result    (result),
    .result_rdy(result_rdy),
    .lost      (lost),
    .busy      (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Edges from the load edge until result_rdy is observed
  function automatic int exp_lat(input logic [4:0] amt);
`ifdef SLL_EARLY_DONE_EN
    if (amt == 5'd0) return 0;
    for (int i = 0; i < 5; i++) if (amt[i]) return 5 - i;
    return 0;
`else
    return 5;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (!reset && result_rdy) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rdy: got result 0x%08h with no op pending (cycle %0d)",
                 result, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("lost", {31'd0, lost}, {31'd0, e.lst});
        check("rdy_cycle", cyc, e.at_cyc);
      end
    end
  end

  // Called at a negedge; the following posedge is the load edge
  task automatic start_op(input logic [31:0] op, input logic [4:0] amt,
                          input logic [31:0] res, input logic lst, input bit push);
    exp_t e;
    operand    = op;
    shift_amt  = amt;
    ctrl_shift = 1'b1;
    if (push) begin
      e.res    = res;
      e.lst    = lst;
      e.at_cyc = cyc + 1 + exp_lat(amt);
      sb.push_back(e);
    end
    @(negedge clock);
    ctrl_shift = 1'b0;
    operand    = $urandom;
    shift_amt  = 5'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clock);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: %0d result(s) still pending, required 0", sb.size());
      sb.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    reset      = 1'b1;
    ctrl_shift = 1'b0;
    operand    = '0;
    shift_amt  = '0;
    repeat (2) @(negedge clock);
    check("reset_result", result, 32'h0);
    check("reset_lost", {31'd0, lost}, 32'd0);
    check("reset_rdy", {31'd0, result_rdy}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    start_op(32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b1);
`ifndef SLL_EARLY_DONE_EN
    check("busy_in_shift", {31'd0, busy}, 32'd1);
`endif
    wait_idle();
    start_op(32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFF0, 1'b1, 1'b1);
    wait_idle();
    start_op(32'h1234_5678, 5'd0, 32'h1234_5678, 1'b0, 1'b1);
    wait_idle();

    // Start during SHIFT must be ignored
    start_op(32'h0000_000F, 5'd8, 32'h0000_0F00, 1'b0, 1'b1);
    @(negedge clock);
    operand    = 32'hDEAD_BEEF;
    shift_amt  = 5'd1;
    ctrl_shift = 1'b1;
    @(negedge clock);
    ctrl_shift = 1'b0;
    wait_idle();

    // Asynchronous reset mid-operation aborts without a pulse
    start_op(32'h0000_0001, 5'd20, 32'h0, 1'b0, 1'b0);
`ifdef SLL_EARLY_DONE_EN
    repeat (2) @(posedge clock);
`else
    repeat (3) @(posedge clock);
`endif
    #2 reset = 1'b1;
    #1;
    check("abort_result", result, 32'h0);
    check("abort_lost", {31'd0, lost}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_rdy", {31'd0, result_rdy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    start_op(32'h8000_0001, 5'd1, 32'h0000_0002, 1'b1, 1'b1);
    wait_idle();

    // Start accepted in the DONE cycle
    start_op(32'h0000_0001, 5'd1, 32'h0000_0002, 1'b0, 1'b1);
    for (int i = 0; i < 20 && !result_rdy; i++) @(negedge clock);
    check("done_cycle_rdy", {31'd0, result_rdy}, 32'd1);
    start_op(32'h0000_0003, 5'd2, 32'h0000_000C, 1'b0, 1'b1);
    check("hold_result", result, 32'h0000_0002);
`ifndef SLL_EARLY_DONE_EN
    check("restart_busy", {31'd0, busy}, 32'd1);
`endif
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
